// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared types and constants for the fetch sequencer and its lane router:
//   - cmd_op_e     : command opcodes accepted from the instruction decoder
//   - state_e      : sequencer FSM states
//   - route_t      : lane-routing bundle produced by fetch_seq_route
//   - WE_* / SEL_* : PE write-strobe masks and PE_SEL codes
//   - beat_count() : DIMEN code to number of beats (2/4/8/16)
//   - is_legal_op(): opcode legality check
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_LOAD_BCAST = 3'd0,
      OP_LOAD_ONE   = 3'd1,
      OP_LOAD_A2X2  = 3'd2,
      OP_LOAD_B2X2  = 3'd3,
      OP_STORE      = 3'd4
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_LOAD,
      ST_STORE,
      ST_FIN
   } state_e;

   // PE write-strobe masks, bit n = PE n
   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam logic [3:0] WE_ALL  = 4'b1111;
   localparam logic [3:0] WE_A_LO = 4'b0011;
   localparam logic [3:0] WE_A_HI = 4'b1100;
   localparam logic [3:0] WE_B_LO = 4'b0101;
   localparam logic [3:0] WE_B_HI = 4'b1010;

   // PE_SEL codes presented to the fetch stage
   localparam logic [1:0] SEL_BCAST = 2'd0;
   localparam logic [1:0] SEL_ONE   = 2'd1;
   localparam logic [1:0] SEL_A2X2  = 2'd2;
   localparam logic [1:0] SEL_B2X2  = 2'd3;

   typedef struct packed {
      logic [1:0] pe_sel;
      logic       sel_2x2;
      logic       sel_4;
      logic [3:0] we_mask;
   } route_t;

   function automatic logic [4:0] beat_count(input logic [1:0] dimen);
      case (dimen)
         2'd0:    return 5'd2;
         2'd1:    return 5'd4;
         2'd2:    return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_STORE);
   endfunction

endpackage

// File: rtl/fetch_seq_route.sv
// -----------------------------------------------------------------------------
// fetch_seq_route
// Pure combinational lane decoder: maps a command opcode and its PE field to
// the fetch-stage lane selects and the PE write-strobe mask.
// Ports:
//   op    in  3  command opcode (cmd_op_e encoding; illegal codes give all-zero)
//   pe    in  2  target PE (LOAD_ONE) / half select in bit 0 (LOAD_A2x2/B2x2)
//   route out    {pe_sel, sel_2x2, sel_4, we_mask}
// -----------------------------------------------------------------------------
module fetch_seq_route
   import fetch_sequencer_pkg::*;
(
   input  logic [2:0] op,
   input  logic [1:0] pe,
   output route_t     route
);

   always_comb begin
      // NOTE: default every field first so no path through the case infers a latch.
      route = '0;
      case (op)
         OP_LOAD_BCAST: begin
            route.pe_sel  = SEL_BCAST;
            route.we_mask = WE_ALL;
         end
         OP_LOAD_ONE: begin
            route.pe_sel                  = SEL_ONE;
            {route.sel_4, route.sel_2x2}  = pe;
            route.we_mask                 = 4'b0001 << pe;
         end
         OP_LOAD_A2X2: begin
            route.pe_sel  = SEL_A2X2;
            route.sel_2x2 = ~pe[0];
            route.we_mask = pe[0] ? WE_A_HI : WE_A_LO;
         end
         OP_LOAD_B2X2: begin
            route.pe_sel  = SEL_B2X2;
            route.sel_2x2 = ~pe[0];
            route.we_mask = pe[0] ? WE_B_HI : WE_B_LO;
         end
         default: begin
            // STORE and illegal codes: no lanes written
            route.we_mask = WE_NONE;
         end
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Command-level sequencer in front of the data-fetch stage. Accepts one
// LOAD/STORE command at a time, runs CLR -> LOAD|STORE -> FIN, drives the
// fetch-stage control pins, generates per-PE write strobes with a beat index,
// and reports completion with a one-cycle DONE pulse.
//
// Optional feature: define FETCH_SEQ_TIMEOUT_EN to enable an 8-bit watchdog on
// the LOAD/STORE phase (limit TIMEOUT_CYCLES). On expiry the sequencer goes to
// FIN with ERR=1 and DONE=0.
//
// Ports:
//   CLK, RST (async, active-high)
//   CMD_VALID/CMD_READY         command handshake (READY high only in IDLE)
//   CMD_OP/DIMEN/ADDR/PE        command fields, latched at accept
//   DIMEN, ADDRESS              registered command copy to fetch stage
//   ADDR_RST, ADDR_START,
//   WRADDR_START                fetch-stage controls
//   PE_SEL, PE_SEL_2x2, PE_SEL_4 lane routing, registered at accept
//   FETCH_DONE, STORE_DONE,
//   LAT_CNT                     fetch-stage status
//   PE_WE, PE_WIDX              PE register-file strobe and beat index
//   BUSY, DONE, ERR             status to decoder
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [2:0]  CMD_OP,
   input  logic [1:0]  CMD_DIMEN,
   input  logic [16:0] CMD_ADDR,
   input  logic [1:0]  CMD_PE,
   output logic [1:0]  DIMEN,
   output logic [16:0] ADDRESS,
   output logic        ADDR_RST,
   output logic        ADDR_START,
   output logic        WRADDR_START,
   output logic [1:0]  PE_SEL,
   output logic        PE_SEL_2x2,
   output logic        PE_SEL_4,
   input  logic        FETCH_DONE,
   input  logic        STORE_DONE,
   input  logic [2:0]  LAT_CNT,
   output logic [3:0]  PE_WE,
   output logic [3:0]  PE_WIDX,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   state_e     state_q;
   logic       is_store_q;
   logic [3:0] we_mask_q;
   route_t     cmd_route;
   logic       beat_fire;
   logic [3:0] widx_last;
   logic       wd_expired;

   fetch_seq_route u_route (
      .op    (CMD_OP),
      .pe    (CMD_PE),
      .route (cmd_route)
   );

   // A beat lands in the PE register files when the fetch read latency
   // counter reaches 2 while loading.
   assign beat_fire = (state_q == ST_LOAD) && (LAT_CNT == 3'd2);
   assign PE_WE     = beat_fire ? we_mask_q : WE_NONE;

   // ADDR_START must drop in the same cycle FETCH_DONE is seen, so it is
   // decoded from the state register and the input rather than registered.
   assign ADDR_START = (state_q == ST_LOAD) && !FETCH_DONE;

   // Last legal beat index for the latched dimension (16 beats -> 15).
   assign widx_last = 4'(beat_count(DIMEN) - 5'd1);

`ifdef FETCH_SEQ_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wd_q;

   // Every entry into LOAD/STORE passes through CLR, so clearing there gives
   // a fresh count for each phase; cycle k of the phase sees wd_q = k-1.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wd_q <= '0;
      end else if (state_q == ST_CLR) begin
         wd_q <= '0;
      end else if (state_q == ST_LOAD || state_q == ST_STORE) begin
         wd_q <= wd_q + 8'd1;
      end
   end

   assign wd_expired = (wd_q == WD_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign wd_expired     = 1'b0;
`endif

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         is_store_q   <= 1'b0;
         we_mask_q    <= WE_NONE;
         CMD_READY    <= 1'b1;
         DIMEN        <= '0;
         ADDRESS      <= '0;
         ADDR_RST     <= 1'b0;
         WRADDR_START <= 1'b0;
         PE_SEL       <= '0;
         PE_SEL_2x2   <= 1'b0;
         PE_SEL_4     <= 1'b0;
         PE_WIDX      <= '0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         ERR          <= 1'b0;
      end else begin
         // single-cycle pulses
         ADDR_RST <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  if (is_legal_op(CMD_OP)) begin
                     state_q    <= ST_CLR;
                     is_store_q <= (CMD_OP == OP_STORE);
                     DIMEN      <= CMD_DIMEN;
                     ADDRESS    <= CMD_ADDR;
                     PE_SEL     <= cmd_route.pe_sel;
                     PE_SEL_2x2 <= cmd_route.sel_2x2;
                     PE_SEL_4   <= cmd_route.sel_4;
                     we_mask_q  <= cmd_route.we_mask;
                     PE_WIDX    <= '0;
                     ADDR_RST   <= 1'b1;
                     BUSY       <= 1'b1;
                     CMD_READY  <= 1'b0;
                  end else begin
                     // illegal op is consumed: flag it and keep waiting
                     ERR <= 1'b1;
                  end
               end
            end

            ST_CLR: begin
               PE_WIDX <= '0;
               if (is_store_q) begin
                  state_q      <= ST_STORE;
                  WRADDR_START <= 1'b1;
               end else begin
                  state_q <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (beat_fire) begin
                  PE_WIDX <= (PE_WIDX == widx_last) ? 4'd0 : PE_WIDX + 4'd1;
               end
               if (FETCH_DONE) begin
                  state_q  <= ST_FIN;
                  ADDR_RST <= 1'b1;
                  DONE     <= 1'b1;
               end else if (wd_expired) begin
                  state_q  <= ST_FIN;
                  ADDR_RST <= 1'b1;
                  ERR      <= 1'b1;
               end
            end

            ST_STORE: begin
               if (STORE_DONE) begin
                  state_q      <= ST_FIN;
                  WRADDR_START <= 1'b0;
                  ADDR_RST     <= 1'b1;
                  DONE         <= 1'b1;
               end else if (wd_expired) begin
                  state_q      <= ST_FIN;
                  WRADDR_START <= 1'b0;
                  ADDR_RST     <= 1'b1;
                  ERR          <= 1'b1;
               end
            end

            ST_FIN: begin
               state_q   <= ST_IDLE;
               BUSY      <= 1'b0;
               CMD_READY <= 1'b1;
            end

            default: begin
               state_q      <= ST_IDLE;
               WRADDR_START <= 1'b0;
               BUSY         <= 1'b0;
               CMD_READY    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Command-level sequencer that sits directly upstream of the data-fetch stage and drives its load and store control pins. It accepts one LOAD or STORE command at a time from the instruction decoder and latches the command fields. It runs the address-reset, fetch or store, and finish sequence, generating per-PE write strobes and a beat index for the PE register files. It reports completion to the decoder with a one-cycle DONE pulse.

## Interface
- TIMEOUT_CYCLES, 255: watchdog limit in cycles for a LOAD/STORE phase (used only with the timeout feature).
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command (high only in IDLE).
- CMD_OP  in  3  0=LOAD_BCAST, 1=LOAD_ONE, 2=LOAD_A2x2, 3=LOAD_B2x2, 4=STORE, 5–7 illegal.
- CMD_DIMEN  in  2  0=2x2, 1=4x4, 2=8x8, 3=16x16+.
- CMD_ADDR  in  17  BRAM base word address.
- CMD_PE  in  2  target PE for LOAD_ONE; bit0 selects the half for LOAD_A2x2/LOAD_B2x2.
- DIMEN  out  2  to fetch stage, registered copy of CMD_DIMEN.
- ADDRESS  out  17  to fetch stage, registered base address.
- ADDR_RST, ADDR_START, WRADDR_START  out  1  fetch-stage controls.
- PE_SEL  out  2; PE_SEL_2x2, PE_SEL_4  out  1  lane routing to fetch stage.
- FETCH_DONE, STORE_DONE  in  1  from fetch stage.
- LAT_CNT  in  3  fetch-stage read-latency counter.
- PE_WE  out  4  per-PE write strobe; one bit per PE.
- PE_WIDX  out  4  beat index for PE_WE.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse on an illegal op or a timeout.

## Operation
- States: IDLE, CLR, LOAD, STORE, FIN.
- IDLE, CMD_VALID=1 and legal op: latch all CMD fields and go to CLR. Illegal op: pulse ERR, stay in IDLE, command consumed.
- CLR: ADDR_RST=1 for exactly one cycle. Next state is STORE if op=4, otherwise LOAD.
- LOAD: ADDR_START=1. When LAT_CNT==2, PE_WE is asserted for the routed lanes and PE_WIDX increments afterwards. On FETCH_DONE=1 go to FIN; ADDR_START drops that same cycle (combinational on state and FETCH_DONE).
- STORE: WRADDR_START=1. On STORE_DONE=1 go to FIN.
- FIN: ADDR_RST=1 and DONE=1 for one cycle, then IDLE.
- Lane routing is registered at command latch:
  - LOAD_BCAST: PE_SEL=0, PE_WE=4'b1111.
  - LOAD_ONE: PE_SEL=1, {PE_SEL_4,PE_SEL_2x2}=CMD_PE, PE_WE=one-hot(CMD_PE).
  - LOAD_A2x2: PE_SEL=2, PE_SEL_2x2=~CMD_PE[0], PE_WE=0011 if CMD_PE[0]=0, else 1100.
  - LOAD_B2x2: PE_SEL=3, PE_SEL_2x2=~CMD_PE[0], PE_WE=0101 if CMD_PE[0]=0, else 1010.
  - STORE: PE_WE=0.
- PE_WIDX clears in CLR. It wraps modulo 16 and never exceeds DIMEN beat count −1.
- RST mid-operation returns to IDLE with all outputs at reset values; the fetch stage is re-zeroed by the next CLR.

## Timing
- Reset values: state=IDLE, CMD_READY=1, every other output 0.
- Command accept to ADDR_RST: 1 cycle. ADDR_RST to first ADDR_START: 1 cycle.
- A LOAD of N beats occupies 3N LOAD cycles (fetch latency of 2 plus 1), followed by the FIN cycle.
- DONE rises one cycle after FETCH_DONE or STORE_DONE is sampled.
- Back-to-back commands: the earliest next accept is the cycle after FIN.
- CMD_VALID with CMD_READY=0 is ignored, not queued.
- FETCH_DONE and STORE_DONE are honoured only in their own state; a spurious assertion in any other state is ignored.

## Configuration
- FETCH_SEQ_TIMEOUT_EN defined: an 8-bit watchdog clears on entry to LOAD/STORE and counts each cycle there. On reaching TIMEOUT_CYCLES the sequencer goes to FIN with DONE=0 and ERR=1 in that FIN cycle. ADDR_RST is still asserted in FIN.
- FETCH_SEQ_TIMEOUT_EN undefined: no counter; LOAD/STORE wait indefinitely; ERR fires only on illegal ops.

## Structure
- Shared package: the CMD_OP enum, the state enum, the DIMEN-to-beat-count function (2/4/8/16), and the PE_WE routing constants.
- Natural sub-module: fetch_seq_route, a pure combinational decoder from (op, CMD_PE) to {PE_SEL, PE_SEL_2x2, PE_SEL_4, PE_WE mask}.
- FSM and watchdog live in the top module.

## Test plan
- Reset, then LOAD_BCAST with DIMEN=0, ADDR=0x100, and a fetch model returning FETCH_DONE after 2 beats. Required: ADDR_RST at t+1, ADDR_START from t+2, PE_WE=1111 on two cycles with PE_WIDX 0 then 1, DONE one cycle after FETCH_DONE.
- LOAD_ONE with CMD_PE=2. Required: PE_SEL=1, PE_SEL_4=1, PE_SEL_2x2=0, PE_WE=0100 on every beat.
- LOAD_B2x2 with CMD_PE[0]=1. Required: PE_SEL=3, PE_SEL_2x2=0, PE_WE=1010.
- STORE with STORE_DONE after 4 cycles. Required: WRADDR_START high for 4 cycles, PE_WE always 0, DONE pulse.
- CMD_OP=6. Required: ERR pulse, BUSY stays 0. RST asserted mid-LOAD. Required: all outputs 0 and CMD_READY=1 immediately.
- With FETCH_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=10, FETCH_DONE held low. Required: ERR=1, DONE=0 after 10 LOAD cycles, then IDLE.
